mem_test_engine: RTL and testbench

Parametrised, synthesizable memory test sequencer for the single-port memory used in the SystemVerilog training labs. It replaces the hand-written, directed write-all/read-all loops with a hardware engine. One `start` pulse runs a full write pass and a full read/compare pass over every address, using a selectable data pattern. The engine reports pass/fail, an error count and the first failing location. It sits directly between the memory's `read`/`write`/`addr`/`data_in`/`data_out` pins and the lab top level.

---
 rtl/mem_test_engine.sv | 146 ++++++++++++++
 tb/tb_mem_test_engine.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_test_engine.sv
// rtl/mem_test_engine.sv - write-all / read-compare memory test sequencer
// Define MEM_TEST_ERR_LOG_EN to keep the first-failure address/data capture.
module mem_test_engine #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic                  read,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr,
    output logic [DATA_WIDTH-1:0] first_fail_data
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                  state;
    logic [1:0]              mode_q;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [2:0]              drain_cnt;
    logic [READ_LATENCY:0]   pipe_valid;
    logic [DATA_WIDTH-1:0]   pipe_exp [READ_LATENCY+1];
    logic                    accept;
    logic                    mismatch;
    logic [ADDR_WIDTH:0]     err_next;

    function automatic logic [DATA_WIDTH-1:0] pattern_of(input logic [ADDR_WIDTH-1:0] a,
                                                         input logic [1:0] m);
        logic [DATA_WIDTH-1:0] cb;
        for (int i = 0; i < DATA_WIDTH; i++) cb[i] = (i % 2 == 0);
        if (a[0]) cb = ~cb;
        case (m)
            2'd0:    return '0;
            2'd1:    return DATA_WIDTH'(a);
            2'd2:    return cb;
            default: return ~DATA_WIDTH'(a);
        endcase
    endfunction

    // The done cycle is already IDLE in the state register; a start there must not launch a test.
    assign accept   = (state == IDLE) && start && !done;
    assign mismatch = pipe_valid[READ_LATENCY] && (data_out !== pipe_exp[READ_LATENCY]);
    assign err_next = err_count + (ADDR_WIDTH+1)'(mismatch);

    // An entry is pushed on the edge that raises read; it matures one edge after the memory latency.
    always_ff @(posedge clk) begin
        pipe_exp[0] <= pattern_of(cnt, mode_q);
        for (int i = 1; i <= READ_LATENCY; i++) pipe_exp[i] <= pipe_exp[i-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode_q     <= 2'd0;
            cnt        <= '0;
            drain_cnt  <= 3'd0;
            pipe_valid <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            addr       <= '0;
            data_in    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
        end else begin
            pipe_valid <= {pipe_valid[READ_LATENCY-1:0], state == READ};
            read       <= 1'b0;
            write      <= 1'b0;
            addr       <= '0;
            data_in    <= '0;
            done       <= 1'b0;
            busy       <= (state != IDLE);
            if (mismatch) err_count <= err_next;

            case (state)
                IDLE: begin
                    if (accept) begin
                        mode_q    <= mode;
                        err_count <= '0;
                        cnt       <= '0;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    write   <= 1'b1;
                    addr    <= cnt;
                    data_in <= pattern_of(cnt, mode_q);
                    cnt     <= cnt + ADDR_WIDTH'(1);
                    if (cnt == LAST_ADDR) state <= READ;
                end
                READ: begin
                    read      <= 1'b1;
                    addr      <= cnt;
                    cnt       <= cnt + ADDR_WIDTH'(1);
                    drain_cnt <= 3'd0;
                    if (cnt == LAST_ADDR) state <= DRAIN;
                end
                DRAIN: begin
                    if (drain_cnt == 3'(READ_LATENCY - 1)) state <= DONE;
                    else drain_cnt <= drain_cnt + 3'd1;
                end
                DONE: begin
                    done  <= 1'b1;
                    pass  <= (err_next == '0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_TEST_ERR_LOG_EN
    logic [ADDR_WIDTH-1:0] pipe_addr [READ_LATENCY+1];

    always_ff @(posedge clk) begin
        pipe_addr[0] <= cnt;
        for (int i = 1; i <= READ_LATENCY; i++) pipe_addr[i] <= pipe_addr[i-1];
        if (!rst_n) begin
            first_fail_addr <= '0;
            first_fail_data <= '0;
        end else if (accept) begin
            first_fail_addr <= '0;
            first_fail_data <= '0;
        end else if (mismatch && err_count == '0) begin
            first_fail_addr <= pipe_addr[READ_LATENCY];
            first_fail_data <= data_out;
        end
    end
`else
    assign first_fail_addr = '0;
    assign first_fail_data = '0;
`endif

endmodule

// File: tb/tb_mem_test_engine.sv
// tb/tb_mem_test_engine.sv - directed vector bench for mem_test_engine
module tb_mem_test_engine;
`ifdef MEM_TEST_ERR_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, read_a, write_a, busy_a, done_a, pass_a;
    logic [1:0] mode_a;
    logic [4:0] addr_a, ffa_a;
    logic [7:0] din_a, dout_a, ffd_a;
    logic [5:0] err_a;

    logic       start_b, read_b, write_b, busy_b, done_b, pass_b;
    logic [1:0] mode_b;
    logic [2:0] addr_b, ffa_b;
    logic [3:0] din_b, dout_b, ffd_b, err_b;

    mem_test_engine u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a),
        .read(read_a), .write(write_a), .addr(addr_a), .data_in(din_a), .data_out(dout_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_fail_addr(ffa_a), .first_fail_data(ffd_a)
    );

    mem_test_engine #(.ADDR_WIDTH(3), .DATA_WIDTH(4), .READ_LATENCY(3)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b),
        .read(read_b), .write(write_b), .addr(addr_b), .data_in(din_b), .data_out(dout_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_fail_addr(ffa_b), .first_fail_data(ffd_b)
    );

    // Memory model A: one-cycle read latency, optional stuck-at-1 bits at one address.
    logic [7:0] mem_a [32];
    logic       preload, fault_en;
    logic [4:0] fault_addr;
    logic [7:0] fault_mask;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem_a[i] <= 8'hA5 ^ 8'(i);
        end else if (write_a) begin
            mem_a[addr_a] <= din_a;
        end
        if (read_a)
            dout_a <= (fault_en && addr_a == fault_addr) ? (mem_a[addr_a] | fault_mask) : mem_a[addr_a];
    end

    // Memory model B: three-cycle read latency, address 2 returns unknown data.
    logic [3:0] mem_b  [8];
    logic [3:0] pipe_b [3];
    always @(posedge clk) begin
        if (write_b) mem_b[addr_b] <= din_b;
        pipe_b[0] <= read_b ? ((addr_b == 3'd2) ? 4'bxxxx : mem_b[addr_b]) : 4'h0;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign dout_b = pipe_b[2];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic run_a(input logic [1:0] m, output int lat);
        @(negedge clk);
        start_a = 1'b1;
        mode_a  = m;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_a) begin
                lat = k;
                break;
            end
        end
    endtask

    typedef struct {
        logic [1:0] mode;
        logic       fault_en;
        logic [4:0] fault_addr;
        logic [7:0] fault_mask;
        logic       exp_pass;
        logic [5:0] exp_err;
        logic [4:0] exp_ffa;
        logic [7:0] exp_ffd;
        logic [7:0] exp_loc6;
    } vec_t;

    vec_t vec [4];

    initial begin
        int lat;
        int nonzero;
        int seen;

        vec[0] = '{2'd0, 1'b0, 5'd0, 8'h00, 1'b1, 6'd0, 5'd0, 8'h00, 8'h00};
        vec[1] = '{2'd1, 1'b1, 5'd5, 8'h08, 1'b0, 6'd1,
                   LOG_EN ? 5'd5 : 5'd0, LOG_EN ? 8'h0D : 8'h00, 8'h06};
        vec[2] = '{2'd2, 1'b0, 5'd0, 8'h00, 1'b1, 6'd0, 5'd0, 8'h00, 8'h55};
        vec[3] = '{2'd3, 1'b0, 5'd0, 8'h00, 1'b1, 6'd0, 5'd0, 8'h00, 8'hF9};

        rst_n = 1'b0; preload = 1'b1; fault_en = 1'b0; fault_addr = '0; fault_mask = '0;
        start_a = 1'b0; mode_a = 2'd0; start_b = 1'b0; mode_b = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset read",    read_a,  0);
        check("reset write",   write_a, 0);
        check("reset addr",    addr_a,  0);
        check("reset data_in", din_a,   0);
        check("reset busy",    busy_a,  0);
        check("reset done",    done_a,  0);
        check("reset pass",    pass_a,  0);
        check("reset err",     err_a,   0);
        check("reset ffa",     ffa_a,   0);
        check("reset ffd",     ffd_a,   0);
        rst_n = 1'b1; preload = 1'b0;

        for (int i = 0; i < 4; i++) begin
            fault_en   = vec[i].fault_en;
            fault_addr = vec[i].fault_addr;
            fault_mask = vec[i].fault_mask;
            run_a(vec[i].mode, lat);
            check($sformatf("v%0d latency", i), lat, 66);
            check($sformatf("v%0d busy at done", i), busy_a, 1);
            check($sformatf("v%0d pass", i), pass_a, vec[i].exp_pass);
            check($sformatf("v%0d err_count", i), err_a, vec[i].exp_err);
            check($sformatf("v%0d first_fail_addr", i), ffa_a, vec[i].exp_ffa);
            check($sformatf("v%0d first_fail_data", i), ffd_a, vec[i].exp_ffd);
            check($sformatf("v%0d mem[6]", i), mem_a[6], vec[i].exp_loc6);
            if (vec[i].mode == 2'd0) begin
                nonzero = 0;
                for (int a = 0; a < 32; a++) if (mem_a[a] != 8'h00) nonzero++;
                check("mode0 nonzero cells", nonzero, 0);
            end
        end
        fault_en = 1'b0;

        // Reset in the middle of a mode-1 test.
        @(negedge clk);
        start_a = 1'b1; mode_a = 2'd1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (39) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset read",  read_a,  0);
        check("midreset write", write_a, 0);
        check("midreset addr",  addr_a,  0);
        check("midreset din",   din_a,   0);
        check("midreset busy",  busy_a,  0);
        check("midreset pass",  pass_a,  0);
        check("midreset err",   err_a,   0);
        seen = 0;
        repeat (80) begin
            @(posedge clk); @(negedge clk);
            if (done_a || busy_a) seen++;
        end
        check("midreset no done/busy", seen, 0);
        run_a(2'd1, lat);
        check("after reset latency", lat, 66);
        check("after reset pass", pass_a, 1);

        // Starts during WRITE and during done are ignored.
        fault_en = 1'b1; fault_addr = 5'd5; fault_mask = 8'h08;
        @(negedge clk);
        start_a = 1'b1; mode_a = 2'd1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            @(negedge clk);
            start_a = (k == 9);
            mode_a  = (k == 9) ? 2'd0 : 2'd1;
            if (done_a) begin
                lat = k;
                break;
            end
        end
        check("ignored start latency", lat, 66);
        check("ignored start err", err_a, 1);
        start_a = 1'b1; mode_a = 2'd2;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        seen = 0;
        repeat (10) begin
            if (busy_a || done_a) seen++;
            @(posedge clk); @(negedge clk);
        end
        check("start at done ignored", seen, 0);
        check("err kept after ignored start", err_a, 1);
        check("pass kept after ignored start", pass_a, 0);
        fault_en = 1'b0;

        // Small configuration with an unknown read at address 2.
        @(negedge clk);
        start_b = 1'b1; mode_b = 2'd1;
        @(posedge clk);
        @(negedge clk);
        start_b = 1'b0;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_b) begin
                lat = k;
                break;
            end
        end
        check("small latency", lat, 20);
        check("small err", err_b, 1);
        check("small pass", pass_b, 0);
        check("small ffa", ffa_b, LOG_EN ? 3'd2 : 3'd0);
        check("small mem[5]", mem_b[5], 4'h5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
